// File: rtl/poly_invntt_frommont.sv
// poly_invntt_frommont: streaming fqmul(coef, F) post-processor for the
// inverse NTT. Each coefficient is multiplied by F (1/128 scaling combined
// with leaving the Montgomery domain) and then Montgomery-reduced.
// The pipeline is stallable, with a valid/ready handshake on both sides.
// Build option FROMMONT_CSUBQ_EN adds a fourth stage that maps the result
// from (-q, q) to the canonical range [0, q).
module poly_invntt_frommont #(
    parameter int KYBER_N          = 256,
    parameter int KYBER_Q          = 3329,
    parameter int MontgomeryR_QINV = 62209,
    parameter int FROMMONT_F       = 1441,
    parameter int i_Coeffs_Width   = 16,
    parameter int o_Coeffs_Width   = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             i_valid,
    output logic                             i_ready,
    input  logic signed [i_Coeffs_Width-1:0] iCoeffs,
    output logic                             o_valid,
    input  logic                             o_ready,
    output logic signed [o_Coeffs_Width-1:0] oCoeffs,
    output logic                             o_last,
    output logic [$clog2(KYBER_N)-1:0]       oCount
);

    localparam int CW = $clog2(KYBER_N);
    localparam logic [CW-1:0]      LAST_IDX = CW'(KYBER_N - 1);
    localparam logic signed [15:0] QINV16   = 16'(MontgomeryR_QINV);
    localparam logic signed [31:0] QINV_S   = 32'(QINV16);
    localparam logic signed [31:0] Q_S      = 32'(KYBER_Q);
    localparam logic signed [31:0] F_S      = 32'(FROMMONT_F);

    // Every stage moves together; a bubble at the output never blocks.
    logic adv;
    assign adv     = !o_valid || o_ready;
    assign i_ready = adv;

    logic signed [31:0] coef_ext;
    logic signed [31:0] p_next;
    assign coef_ext = 32'(iCoeffs);
    assign p_next   = coef_ext * F_S;

    logic               v1_reg;
    logic signed [31:0] p1_reg;
    logic [CW-1:0]      cnt1_reg;
    logic [CW-1:0]      in_cnt_reg;

    // Stage 1: capture coef*F and tag it with the running input index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_reg     <= 1'b0;
            p1_reg     <= '0;
            cnt1_reg   <= '0;
            in_cnt_reg <= '0;
        end else if (adv) begin
            v1_reg <= i_valid;
            if (i_valid) begin
                p1_reg     <= p_next;
                cnt1_reg   <= in_cnt_reg;
                in_cnt_reg <= (in_cnt_reg == LAST_IDX) ? '0 : in_cnt_reg + 1'b1;
            end
        end
    end

    // Montgomery quotient: only the low 16 bits of p*QINV matter.
    logic signed [15:0] t_next;
    assign t_next = 16'(p1_reg * QINV_S);

    logic               v2_reg;
    logic signed [31:0] p2_reg;
    logic signed [15:0] t2_reg;
    logic [CW-1:0]      cnt2_reg;

    // Stage 2: register the quotient alongside the product and its tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2_reg   <= 1'b0;
            p2_reg   <= '0;
            t2_reg   <= '0;
            cnt2_reg <= '0;
        end else if (adv) begin
            v2_reg   <= v1_reg;
            p2_reg   <= p1_reg;
            t2_reg   <= t_next;
            cnt2_reg <= cnt1_reg;
        end
    end

    // Low half of p - t*q is zero by construction; the high half is the result.
    logic signed [31:0] qt;
    logic signed [31:0] diff;
    logic signed [o_Coeffs_Width-1:0] r_next;
    assign qt     = 32'(t2_reg) * Q_S;
    assign diff   = p2_reg - qt;
    assign r_next = o_Coeffs_Width'(diff >>> 16);

    logic                             s3_valid_reg;
    logic signed [o_Coeffs_Width-1:0] s3_data_reg;
    logic                             s3_last_reg;
    logic [CW-1:0]                    s3_cnt_reg;

    // Stage 3: reduced coefficient with its index and end-of-polynomial flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_valid_reg <= 1'b0;
            s3_data_reg  <= '0;
            s3_last_reg  <= 1'b0;
            s3_cnt_reg   <= '0;
        end else if (adv) begin
            s3_valid_reg <= v2_reg;
            s3_data_reg  <= r_next;
            s3_last_reg  <= (cnt2_reg == LAST_IDX);
            s3_cnt_reg   <= cnt2_reg;
        end
    end

`ifdef FROMMONT_CSUBQ_EN
    logic signed [o_Coeffs_Width-1:0] csub_next;
    assign csub_next = (s3_data_reg < 0) ? s3_data_reg + o_Coeffs_Width'(KYBER_Q)
                                         : s3_data_reg;

    logic                             s4_valid_reg;
    logic signed [o_Coeffs_Width-1:0] s4_data_reg;
    logic                             s4_last_reg;
    logic [CW-1:0]                    s4_cnt_reg;

    // Stage 4: conditional add of q gives a canonical [0, q) result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s4_valid_reg <= 1'b0;
            s4_data_reg  <= '0;
            s4_last_reg  <= 1'b0;
            s4_cnt_reg   <= '0;
        end else if (adv) begin
            s4_valid_reg <= s3_valid_reg;
            s4_data_reg  <= csub_next;
            s4_last_reg  <= s3_last_reg;
            s4_cnt_reg   <= s3_cnt_reg;
        end
    end

    assign o_valid = s4_valid_reg;
    assign oCoeffs = s4_data_reg;
    assign o_last  = s4_last_reg;
    assign oCount  = s4_cnt_reg;
`else
    assign o_valid = s3_valid_reg;
    assign oCoeffs = s3_data_reg;
    assign o_last  = s3_last_reg;
    assign oCount  = s3_cnt_reg;
`endif

endmodule

// File: tb/tb_poly_invntt_frommont.sv
// Scoreboarded bench for poly_invntt_frommont. Expected results come from a
// behavioural fqmul model and are queued on each input transfer, then
// compared on each output transfer. Also builds with FROMMONT_CSUBQ_EN.
module tb_poly_invntt_frommont;

`ifdef FROMMONT_CSUBQ_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               i_valid;
    logic               i_ready;
    logic signed [15:0] iCoeffs;
    logic               o_valid;
    logic               o_ready;
    logic signed [15:0] oCoeffs;
    logic               o_last;
    logic [7:0]         oCount;

    always #5 clk = ~clk;

    poly_invntt_frommont dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .iCoeffs (iCoeffs),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .oCoeffs (oCoeffs),
        .o_last  (o_last),
        .oCount  (oCount)
    );

    typedef struct {
        int data;
        int cnt;
        int last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   in_idx = 0;
    int   pushes = 0;
    int   pops   = 0;
    int   last_seen = 0;
    bit   hold_pend = 0;
    int   hold_d, hold_c, hold_l;

    // C-style fqmul(a, 1441) followed by the optional canonicalisation.
    function automatic int model(int a);
        int      p;
        shortint t;
        int      r;
        p = a * 1441;
        t = shortint'(p * (-3327));
        r = (p - int'(t) * 3329) >>> 16;
`ifdef FROMMONT_CSUBQ_EN
        if (r < 0) r = r + 3329;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: evaluate handshakes at the falling edge, return just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (reset_n) begin
            if (hold_pend) begin
                check("hold_valid", int'(o_valid), 1);
                check("hold_data", int'(oCoeffs), hold_d);
                check("hold_cnt", int'(oCount), hold_c);
                check("hold_last", int'(o_last), hold_l);
            end
            if (i_valid && i_ready) begin
                e.data = model(int'(iCoeffs));
                e.cnt  = in_idx;
                e.last = (in_idx == 255) ? 1 : 0;
                sb.push_back(e);
                in_idx = (in_idx + 1) % 256;
                pushes++;
            end
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", int'(oCoeffs), e.data);
                    check("out_cnt", int'(oCount), e.cnt);
                    check("out_last", int'(o_last), e.last);
                    if (o_last) last_seen++;
                    pops++;
                end
            end
            hold_pend = o_valid && !o_ready;
            hold_d    = int'(oCoeffs);
            hold_c    = int'(oCount);
            hold_l    = int'(o_last);
        end else begin
            hold_pend = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_valid = 1'b0;
        #1;
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_oCoeffs", int'(oCoeffs), 0);
        check("rst_oCount", int'(oCount), 0);
        check("rst_o_last", int'(o_last), 0);
        sb.delete();
        in_idx    = 0;
        hold_pend = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        i_valid = 1'b0;
        o_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    // Single coefficient into an idle pipeline: measure latency and the result.
    task automatic lat_test(input int value, input int expected, input int exp_cnt);
        int n;
        iCoeffs = 16'(value);
        i_valid = 1'b1;
        o_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 10) begin
            tick();
            n++;
        end
        check("latency", n, LAT);
        check("lat_data", int'(oCoeffs), expected);
        check("lat_cnt", int'(oCount), exp_cnt);
    endtask

    initial begin
        int n;
        int target;
        reset_n = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        iCoeffs = '0;
        #2;
        do_reset();

        // Directed single values.
        lat_test(1, 512, 0);
`ifdef FROMMONT_CSUBQ_EN
        lat_test(-1, 2817, 1);
`else
        lat_test(-1, -512, 1);
`endif
        lat_test(0, 0, 2);
        drain();

        // Two full polynomials back-to-back.
        do_reset();
        last_seen = 0;
        pops      = 0;
        o_ready   = 1'b1;
        for (int i = 0; i < 512; i++) begin
            iCoeffs = 16'($urandom);
            i_valid = 1'b1;
            tick();
        end
        drain();
        check("poly_outputs", pops, 512);
        check("last_count", last_seen, 2);

        // Output stall mid-stream with the input still offered.
        for (int i = 0; i < 40; i++) begin
            iCoeffs = 16'($urandom);
            i_valid = 1'b1;
            o_ready = !(i >= 10 && i < 15);
            if (i == 12) begin
                #1;
                check("stall_i_ready", int'(i_ready), 0);
            end
            tick();
        end
        drain();

        // Random handshake toggling over 1024 accepted coefficients.
        target = pushes + 1024;
        n = 0;
        while (pushes < target && n < 20000) begin
            i_valid = 1'($urandom_range(0, 1));
            o_ready = 1'($urandom_range(0, 1));
            iCoeffs = 16'($urandom);
            tick();
            n++;
        end
        check("random_timeout", int'(pushes >= target), 1);
        drain();

        // Reset in the middle of a polynomial.
        do_reset();
        o_ready = 1'b1;
        n = 0;
        while (in_idx < 100 && n < 200) begin
            iCoeffs = 16'($urandom);
            i_valid = 1'b1;
            tick();
            n++;
        end
        reset_n = 1'b0;
        #1;
        check("midrst_o_valid", int'(o_valid), 0);
        check("midrst_o_last", int'(o_last), 0);
        sb.delete();
        in_idx    = 0;
        hold_pend = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        lat_test(5, model(5), 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
